// File: rtl/pipe_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_chain_if                                                |
// | Description : Upstream/downstream valid-ready handshake bundle for the      |
// |               elastic pipeline chain.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_chain_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_chain                                                   |
// | Description : Elastic valid/ready register chain with bubble collapse,     |
// |               per-slot flush, occupancy and saturating stall statistics.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_chain #(
  parameter int                NUM_STAGES = 4,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  parameter int                CNT_W      = 16,
  localparam int               OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  pipe_chain_if.slave           bus,
  input  logic [NUM_STAGES-1:0] flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int              c_last    = NUM_STAGES - 1;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [NUM_STAGES-1:0] r_valid;
  logic [DATA_W-1:0]     r_data [NUM_STAGES];
  logic [OCC_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_stall;

  logic [NUM_STAGES-1:0] w_live;
  logic [NUM_STAGES-1:0] w_down;
  logic [NUM_STAGES-1:0] w_take;
  logic [NUM_STAGES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]      w_occ_nxt;
  logic                  w_head_rdy;
  logic                  w_stall_inc;

  // A flushed slot is treated as empty for the whole cycle.
  assign w_live = r_valid & ~flush;

  // w_down[i] is the readiness of whatever sits after slot i (next slot or downstream).
  always_comb begin : comb_ready
    logic w_chain;
    w_chain = bus.out_ready;
    w_down  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_down[i] = w_chain;
      w_chain   = ~w_live[i] | w_chain;
    end
    w_head_rdy = w_chain;
  end

  always_comb begin : comb_next
    w_take      = '0;
    w_valid_nxt = '0;
    w_occ_nxt   = '0;
    w_take[0]   = bus.in_valid & en & w_head_rdy;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_take[i] = w_live[i-1] & w_down[i-1];
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_valid_nxt[i] = w_take[i] | (w_live[i] & ~w_down[i]);
      w_occ_nxt      = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
    end
  end

  assign w_stall_inc = bus.out_valid & ~bus.out_ready & (r_stall != c_cnt_max);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_valid <= '0;
      r_occ   <= '0;
      r_stall <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_data[i] <= PRESET_VAL;
      end
    end else if (en) begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      if (w_stall_inc) begin
        r_stall <= r_stall + CNT_W'(1);
      end
      // An incoming entry wins over a flush of the same slot.
      if (w_take[0]) begin
        r_data[0] <= bus.in_data;
      end else if (flush[0]) begin
        r_data[0] <= PRESET_VAL;
      end
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (w_take[i]) begin
          r_data[i] <= r_data[i-1];
        end else if (flush[i]) begin
          r_data[i] <= PRESET_VAL;
        end
      end
    end
  end

  assign bus.in_ready  = en & w_head_rdy;
  assign bus.out_valid = en & w_live[c_last];
  assign bus.out_data  = r_data[c_last];
  assign stage_valid   = r_valid;
  assign occupancy     = r_occ;
  assign stall_cnt     = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// Bench for pipe_chain (N=4): hand-derived per-cycle vector table, corner-case
// sequences, and a scoreboard for ordered random traffic.
module tb_pipe_chain;
  localparam int          N  = 4;
  localparam int          DW = 32;
  localparam int          CW = 4;
  localparam logic [31:0] P  = 32'hDEAD_BEEF;

  logic       clk   = 1'b0;
  logic       arst  = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] flush = 4'h0;
  logic [3:0] stage_valid;
  logic [2:0] occupancy;
  logic [3:0] stall_cnt;

  pipe_chain_if #(.DATA_W(DW)) bus ();

  pipe_chain #(
    .NUM_STAGES (N),
    .DATA_W     (DW),
    .PRESET_VAL (P),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .en          (en),
    .bus         (bus),
    .flush       (flush),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  fl;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        c_od;
    logic [3:0]  e_sv;
    logic [2:0]  e_occ;
    logic [3:0]  e_st;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  bit          sb_on = 1'b0;

  function automatic void add(input logic e, input logic iv, input logic [31:0] id,
                              input logic ordy, input logic [3:0] fl, input logic irdy,
                              input logic ov, input logic [31:0] od, input logic c_od,
                              input logic [3:0] sv, input logic [2:0] occ, input logic [3:0] st);
    vec_t v;
    v.en = e; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_irdy = irdy; v.e_ov = ov; v.e_od = od; v.c_od = c_od;
    v.e_sv = sv; v.e_occ = occ; v.e_st = st;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic [3:0] fl);
    en            = e;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
  endtask

  task automatic adv();
    if (sb_on) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got out_data %h, want no output", bus.out_data);
        end else begin
          chk("sb_data", bus.out_data, sb_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic irdy, input logic ov,
                              input logic [31:0] od, input logic c_od, input logic [3:0] sv,
                              input logic [2:0] occ, input logic [3:0] st);
    chk({tag, "_in_ready"},    32'(bus.in_ready),  32'(irdy));
    chk({tag, "_out_valid"},   32'(bus.out_valid), 32'(ov));
    if (c_od) chk({tag, "_out_data"}, bus.out_data, od);
    chk({tag, "_stage_valid"}, 32'(stage_valid),   32'(sv));
    chk({tag, "_occupancy"},   32'(occupancy),     32'(occ));
    chk({tag, "_stall_cnt"},   32'(stall_cnt),     32'(st));
  endtask

  initial begin
    logic e, iv, ordy;

    // Stream three entries, unstalled.
    add(1,1,32'h11,1,4'h0, 1,0,P,1,    4'b0000,3'd0,4'd0);
    add(1,1,32'h22,1,4'h0, 1,0,P,1,    4'b0001,3'd1,4'd0);
    add(1,1,32'h33,1,4'h0, 1,0,P,1,    4'b0011,3'd2,4'd0);
    add(1,0,32'h0 ,1,4'h0, 1,0,P,1,    4'b0111,3'd3,4'd0);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'h11,1,4'b1110,3'd3,4'd0);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'h22,1,4'b1100,3'd2,4'd0);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'h33,1,4'b1000,3'd1,4'd0);
    // Fill while stalled, then release.
    add(1,1,32'hA1,0,4'h0, 1,0,P,0,    4'b0000,3'd0,4'd0);
    add(1,1,32'hA2,0,4'h0, 1,0,P,0,    4'b0001,3'd1,4'd0);
    add(1,1,32'hA3,0,4'h0, 1,0,P,0,    4'b0011,3'd2,4'd0);
    add(1,1,32'hA4,0,4'h0, 1,0,P,0,    4'b0111,3'd3,4'd0);
    add(1,1,32'hA5,0,4'h0, 0,1,32'hA1,1,4'b1111,3'd4,4'd0);
    add(1,1,32'hA5,0,4'h0, 0,1,32'hA1,1,4'b1111,3'd4,4'd1);
    add(1,1,32'hA5,0,4'h0, 0,1,32'hA1,1,4'b1111,3'd4,4'd2);
    add(1,1,32'hA5,1,4'h0, 1,1,32'hA1,1,4'b1111,3'd4,4'd3);
    add(1,0,32'h0 ,0,4'h0, 0,1,32'hA2,1,4'b1111,3'd4,4'd3);
    // Bubble in slot 1 while slot 3 is stalled.
    add(1,1,32'hB1,0,4'h2, 1,1,32'hA2,1,4'b1111,3'd4,4'd4);
    add(1,1,32'hB2,0,4'h0, 0,1,32'hA2,1,4'b1111,3'd4,4'd5);
    // Flush the two middle slots while draining.
    add(1,0,32'h0 ,1,4'h6, 1,1,32'hA2,1,4'b1111,3'd4,4'd6);
    add(1,0,32'h0 ,1,4'h0, 1,0,P,0,    4'b0010,3'd1,4'd6);
    add(1,0,32'h0 ,1,4'h0, 1,0,P,0,    4'b0100,3'd1,4'd6);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'hB1,1,4'b1000,3'd1,4'd6);
    // Flush of the oldest slot with and without an incoming entry.
    add(1,1,32'hC1,0,4'h0, 1,0,P,0,    4'b0000,3'd0,4'd6);
    add(1,1,32'hC2,0,4'h0, 1,0,P,0,    4'b0001,3'd1,4'd6);
    add(1,0,32'h0 ,0,4'h0, 1,0,P,0,    4'b0011,3'd2,4'd6);
    add(1,0,32'h0 ,0,4'h0, 1,0,P,0,    4'b0110,3'd2,4'd6);
    add(1,0,32'h0 ,1,4'h8, 1,0,32'hC1,1,4'b1100,3'd2,4'd6);
    add(1,0,32'h0 ,0,4'h0, 1,1,32'hC2,1,4'b1000,3'd1,4'd6);
    add(1,0,32'h0 ,0,4'h8, 1,0,32'hC2,1,4'b1000,3'd1,4'd7);
    // Flush of slot 2 while slot 1 advances into it.
    add(1,1,32'hE1,0,4'h0, 1,0,P,1,    4'b0000,3'd0,4'd7);
    add(1,1,32'hE2,0,4'h0, 1,0,P,1,    4'b0001,3'd1,4'd7);
    add(1,1,32'hE3,0,4'h0, 1,0,P,1,    4'b0011,3'd2,4'd7);
    add(1,0,32'h0 ,0,4'h0, 1,0,P,1,    4'b0111,3'd3,4'd7);
    add(1,0,32'h0 ,0,4'h4, 1,1,32'hE1,1,4'b1110,3'd3,4'd7);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'hE1,1,4'b1100,3'd2,4'd8);
    add(1,0,32'h0 ,1,4'h0, 1,1,32'hE3,1,4'b1000,3'd1,4'd8);
    add(1,0,32'h0 ,1,4'h0, 1,0,P,0,    4'b0000,3'd0,4'd8);

    // Reset state.
    en = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1 arst = 1'b1;
    #2;
    expect_state("reset", 1, 0, P, 1, 4'b0000, 3'd0, 4'd0);
    @(negedge clk);
    arst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      expect_state($sformatf("v%0d", i), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_od,
                   tbl[i].c_od, tbl[i].e_sv, tbl[i].e_occ, tbl[i].e_st);
      adv();
    end

    // Stall counter saturation (starts at 8, max 15).
    drive(1,1,32'hF1,0,4'h0); adv();
    drive(1,1,32'hF2,0,4'h0); adv();
    drive(1,1,32'hF3,0,4'h0); adv();
    drive(1,0,32'h0 ,0,4'h0); adv();
    drive(1,0,32'h0 ,0,4'h0);
    expect_state("sat_start", 1, 1, 32'hF1, 1, 4'b1110, 3'd3, 4'd8);
    for (int k = 0; k < 7; k++) begin drive(1,0,32'h0,0,4'h0); adv(); end
    drive(1,0,32'h0,0,4'h0);
    expect_state("sat_max", 1, 1, 32'hF1, 1, 4'b1110, 3'd3, 4'd15);
    for (int k = 0; k < 5; k++) begin drive(1,0,32'h0,0,4'h0); adv(); end
    drive(1,0,32'h0,0,4'h0);
    expect_state("sat_hold", 1, 1, 32'hF1, 1, 4'b1110, 3'd3, 4'd15);

    // Asynchronous reset mid-cycle with three entries in flight.
    #2 arst = 1'b1;
    #1;
    expect_state("arst_async", 1, 0, P, 1, 4'b0000, 3'd0, 4'd0);
    @(negedge clk);
    arst = 1'b0;
    drive(1,0,32'h0,0,4'h0);
    expect_state("arst_after", 1, 0, P, 1, 4'b0000, 3'd0, 4'd0);
    adv();

    // Global enable low freezes everything, flush included.
    drive(1,1,32'h6001,0,4'h0); adv();
    drive(1,1,32'h6002,0,4'h0); adv();
    drive(1,0,32'h0   ,0,4'h0); adv();
    drive(1,0,32'h0   ,0,4'h0); adv();
    drive(1,0,32'h0,0,4'h0);
    expect_state("en_pre", 1, 1, 32'h6001, 1, 4'b1100, 3'd2, 4'd0);
    adv();
    for (int k = 0; k < 5; k++) begin
      drive(0,1,32'h77,1,4'hF);
      expect_state($sformatf("en_off%0d", k), 0, 0, 32'h6001, 1, 4'b1100, 3'd2, 4'd1);
      adv();
    end
    drive(1,0,32'h0,1,4'h0);
    expect_state("en_on0", 1, 1, 32'h6001, 1, 4'b1100, 3'd2, 4'd1);
    adv();
    drive(1,0,32'h0,1,4'h0);
    expect_state("en_on1", 1, 1, 32'h6002, 1, 4'b1000, 3'd1, 4'd1);
    adv();
    drive(1,0,32'h0,1,4'h0);
    expect_state("en_on2", 1, 0, 32'h0, 0, 4'b0000, 3'd0, 4'd1);
    adv();

    // Random ordered traffic against the scoreboard.
    sb_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      e    = ($urandom_range(0, 7) != 0);
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 2) != 0);
      drive(e, iv, $urandom, ordy, 4'h0);
      chk("rnd_occ", 32'(occupancy), 32'(sb_q.size()));
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(e & ((sb_q.size() < N) | ordy)));
      chk("rnd_ov_gated", 32'(bus.out_valid & ~e), 32'd0);
      adv();
    end
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
      drive(1,0,32'h0,1,4'h0);
      adv();
    end
    drive(1,0,32'h0,1,4'h0);
    chk("drain_queue", 32'(sb_q.size()), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
